// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between a CPU memory stage
// (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory serving one load/store at a time with a
// programmable number of wait states between acceptance and response.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2,
  parameter int INIT_ID = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic [15:0]       txn_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef logic [DEPTH-1:0][31:0] mem_image_t;

  function automatic mem_image_t init_image();
    mem_image_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = (INIT_ID != 0) ? 32'(i) : 32'd0;
    end
    return img;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Power-up image only; reset deliberately leaves the array untouched.
  mem_image_t mem_q = init_image();

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;
  logic [15:0] txn_q, txn_d;

  logic [29:0]      acc_idx_full;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_err;
  logic [31:0]      cur_word;
  logic             mem_we;
  logic [31:0]      mem_wword;

  // Next-state, capture and access logic for the single outstanding request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    valid_d   = valid_q;
    txn_d     = txn_q;
    mem_we    = 1'b0;
    mem_wword = 32'd0;

    acc_idx_full = addr_q[31:2];
    acc_err      = (addr_q[1:0] != 2'b00) || (acc_idx_full >= 30'(DEPTH));
    acc_idx      = acc_idx_full[IDX_W-1:0];
    cur_word     = mem_q[acc_idx];

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          cnt_d   = 4'(LATENCY);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          if (acc_err) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else if (write_q) begin
            mem_we    = 1'b1;
            mem_wword = merge_bytes(cur_word, wdata_q, wstrb_q);
            rdata_d   = 32'd0;
            err_d     = 1'b0;
          end else begin
            rdata_d = cur_word;
            err_d   = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          txn_d   = (txn_q == 16'hFFFF) ? txn_q : (txn_q + 16'd1);
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        rdata_d = 32'd0;
        err_d   = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      txn_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      txn_q   <= txn_d;
    end
  end

  // Store commit; suppressed while reset is asserted so a pending store is dropped.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[acc_idx] <= mem_wword;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign txn_count     = txn_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (2 and 0 wait states)
// checked every cycle against a transaction-level model plus literal values.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v       [2];
  logic        req_valid_v [2];
  logic        req_write_v [2];
  logic [31:0] req_addr_v  [2];
  logic [31:0] req_wdata_v [2];
  logic [3:0]  req_wstrb_v [2];
  logic        rsp_ready_v [2];

  logic        ready_o [2];
  logic        valid_o [2];
  logic [31:0] rdata_o [2];
  logic        err_o   [2];
  logic [15:0] txn_o   [2];
  logic [15:0] txn0, txn1;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign bus0.req_valid = req_valid_v[0];
  assign bus0.req_write = req_write_v[0];
  assign bus0.req_addr  = req_addr_v[0];
  assign bus0.req_wdata = req_wdata_v[0];
  assign bus0.req_wstrb = req_wstrb_v[0];
  assign bus0.rsp_ready = rsp_ready_v[0];
  assign bus1.req_valid = req_valid_v[1];
  assign bus1.req_write = req_write_v[1];
  assign bus1.req_addr  = req_addr_v[1];
  assign bus1.req_wdata = req_wdata_v[1];
  assign bus1.req_wstrb = req_wstrb_v[1];
  assign bus1.rsp_ready = rsp_ready_v[1];

  assign ready_o[0] = bus0.req_ready;
  assign valid_o[0] = bus0.rsp_valid;
  assign rdata_o[0] = bus0.rsp_rdata;
  assign err_o[0]   = bus0.rsp_err;
  assign txn_o[0]   = txn0;
  assign ready_o[1] = bus1.req_ready;
  assign valid_o[1] = bus1.rsp_valid;
  assign rdata_o[1] = bus1.rsp_rdata;
  assign err_o[1]   = bus1.rsp_err;
  assign txn_o[1]   = txn1;

  dmem_responder #(.DEPTH(128), .LATENCY(2), .INIT_ID(1)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .bus(bus0.slave), .txn_count(txn0));
  dmem_responder #(.DEPTH(128), .LATENCY(0), .INIT_ID(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .bus(bus1.slave), .txn_count(txn1));

  // ---------------- transaction-level model ----------------
  int          lat_of [2] = '{2, 0};
  int          edge_no = 0;
  bit          m_inited = 1'b0;
  logic [31:0] m_mem   [2][128];
  logic        m_busy  [2];
  logic        m_valid [2];
  logic [31:0] m_rdata [2];
  logic        m_err   [2];
  int          m_count [2];
  int          m_due   [2];
  logic        m_write [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wstrb [2];

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd128);
  endfunction

  always @(posedge clk) begin
    edge_no <= edge_no + 1;
    if (!m_inited) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 128; j++) m_mem[i][j] <= 32'(j);
      m_inited <= 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (!rst_v[i]) begin
        m_busy[i] <= 1'b0; m_valid[i] <= 1'b0; m_rdata[i] <= 32'd0;
        m_err[i] <= 1'b0; m_count[i] <= 0;
      end else if (!m_busy[i]) begin
        if (req_valid_v[i]) begin
          m_busy[i]  <= 1'b1;
          m_write[i] <= req_write_v[i];
          m_addr[i]  <= req_addr_v[i];
          m_wdata[i] <= req_wdata_v[i];
          m_wstrb[i] <= req_wstrb_v[i];
          m_due[i]   <= edge_no + 1 + lat_of[i];
        end
      end else if (m_valid[i]) begin
        if (rsp_ready_v[i]) begin
          m_busy[i] <= 1'b0; m_valid[i] <= 1'b0; m_rdata[i] <= 32'd0; m_err[i] <= 1'b0;
          m_count[i] <= (m_count[i] >= 65535) ? 65535 : m_count[i] + 1;
        end
      end else if (edge_no == m_due[i]) begin
        m_valid[i] <= 1'b1;
        if (bad_addr(m_addr[i])) begin
          m_err[i] <= 1'b1; m_rdata[i] <= 32'd0;
        end else if (m_write[i]) begin
          m_err[i] <= 1'b0; m_rdata[i] <= 32'd0;
          for (int b = 0; b < 4; b++)
            if (m_wstrb[i][b]) m_mem[i][m_addr[i][8:2]][8*b +: 8] <= m_wdata[i][8*b +: 8];
        end else begin
          m_err[i] <= 1'b0; m_rdata[i] <= m_mem[i][m_addr[i][8:2]];
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, i, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk("req_ready", i, 32'(ready_o[i]), 32'(!m_busy[i]));
      chk("rsp_valid", i, 32'(valid_o[i]), 32'(m_valid[i]));
      chk("rsp_rdata", i, rdata_o[i], m_rdata[i]);
      chk("rsp_err",   i, 32'(err_o[i]), 32'(m_err[i]));
      chk("txn_count", i, 32'(txn_o[i]), 32'(m_count[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (chk_on) compare_all();
  endtask

  task automatic wait_rsp(input int i, output logic [31:0] rd, output logic er, output int lat);
    lat = 0;
    while (!valid_o[i] && lat < 40) begin
      tick();
      lat++;
    end
    if (!valid_o[i]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_timeout[%0d]: got no rsp_valid after %0d cycles, required within 40", i, lat);
    end
    rd = rdata_o[i];
    er = err_o[i];
  endtask

  task automatic do_txn(input int i, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rd, output logic er, output int lat);
    req_write_v[i] = wr;
    req_addr_v[i]  = addr;
    req_wdata_v[i] = wdata;
    req_wstrb_v[i] = strb;
    req_valid_v[i] = 1'b1;
    rsp_ready_v[i] = 1'b1;
    tick();
    req_valid_v[i] = 1'b0;
    wait_rsp(i, rd, er, lat);
    tick();
  endtask

  task automatic reset_in_wait(input int i);
    logic [31:0] rd;
    logic        er;
    int          lat;
    req_write_v[i] = 1'b1;
    req_addr_v[i]  = 32'h0000_000C;
    req_wdata_v[i] = 32'h1234_5678;
    req_wstrb_v[i] = 4'b1111;
    req_valid_v[i] = 1'b1;
    tick();
    req_valid_v[i] = 1'b0;
    rst_v[i] = 1'b0;
    tick();
    rst_v[i] = 1'b1;
    chk("rstw_ready", i, 32'(ready_o[i]), 32'd1);
    chk("rstw_valid", i, 32'(valid_o[i]), 32'd0);
    chk("rstw_rdata", i, rdata_o[i], 32'd0);
    chk("rstw_txn",   i, 32'(txn_o[i]), 32'd0);
    do_txn(i, 1'b0, 32'h0000_000C, 32'd0, 4'd0, rd, er, lat);
    chk("rstw_load", i, rd, 32'h0000_0003);
    chk("rstw_lat",  i, 32'(lat), 32'(lat_of[i] + 1));
    chk("rstw_cnt",  i, 32'(txn_o[i]), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b0; req_valid_v[i] = 1'b0; req_write_v[i] = 1'b0;
      req_addr_v[i] = 32'd0; req_wdata_v[i] = 32'd0; req_wstrb_v[i] = 4'd0;
      rsp_ready_v[i] = 1'b1;
    end
    tick();
    chk_on = 1'b1;
    tick();
    rst_v[0] = 1'b1;
    rst_v[1] = 1'b1;
    chk("reset_ready", 0, 32'(ready_o[0]), 32'd1);
    chk("reset_valid", 0, 32'(valid_o[0]), 32'd0);
    chk("reset_txn",   0, 32'(txn_o[0]), 32'd0);

    // Instance 0: two wait states
    do_txn(0, 1'b0, 32'h0000_0010, 32'd0, 4'd0, rd, er, lat);
    chk("load10_rdata", 0, rd, 32'h0000_0004);
    chk("load10_err",   0, 32'(er), 32'd0);
    chk("load10_lat",   0, 32'(lat), 32'd3);
    chk("load10_txn",   0, 32'(txn_o[0]), 32'd1);

    do_txn(0, 1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0011, rd, er, lat);
    chk("st08_rdata", 0, rd, 32'd0);
    chk("st08_err",   0, 32'(er), 32'd0);
    do_txn(0, 1'b0, 32'h0000_0008, 32'd0, 4'd0, rd, er, lat);
    chk("ld08_rdata", 0, rd, 32'h0000_CCDD);

    // Back-pressure: response held while a second request waits
    rsp_ready_v[0] = 1'b0;
    req_write_v[0] = 1'b0;
    req_addr_v[0]  = 32'h0000_0014;
    req_valid_v[0] = 1'b1;
    tick();
    req_valid_v[0] = 1'b0;
    wait_rsp(0, rd, er, lat);
    req_addr_v[0]  = 32'h0000_0004;
    req_valid_v[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_ready", 0, 32'(ready_o[0]), 32'd0);
      chk("bp_valid", 0, 32'(valid_o[0]), 32'd1);
      chk("bp_rdata", 0, rdata_o[0], 32'h0000_0005);
    end
    rsp_ready_v[0] = 1'b1;
    tick();
    chk("bp_idle", 0, 32'(ready_o[0]), 32'd1);
    tick();
    req_valid_v[0] = 1'b0;
    chk("bp_accept", 0, 32'(ready_o[0]), 32'd0);
    wait_rsp(0, rd, er, lat);
    chk("bp_queued_rdata", 0, rd, 32'h0000_0001);
    tick();

    do_txn(0, 1'b0, 32'h0000_0006, 32'd0, 4'd0, rd, er, lat);
    chk("mis_err",   0, 32'(er), 32'd1);
    chk("mis_rdata", 0, rd, 32'd0);
    do_txn(0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b1111, rd, er, lat);
    chk("oor_err", 0, 32'(er), 32'd1);
    do_txn(0, 1'b0, 32'h0000_01FC, 32'd0, 4'd0, rd, er, lat);
    chk("ld1fc_rdata", 0, rd, 32'h0000_007F);
    chk("ld1fc_err",   0, 32'(er), 32'd0);
    do_txn(0, 1'b1, 32'h0000_0018, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    chk("nostrb_err", 0, 32'(er), 32'd0);
    do_txn(0, 1'b0, 32'h0000_0018, 32'd0, 4'd0, rd, er, lat);
    chk("nostrb_rdata", 0, rd, 32'h0000_0006);
    chk("txn_ten", 0, 32'(txn_o[0]), 32'd10);
    reset_in_wait(0);

    // Instance 1: zero wait states
    do_txn(1, 1'b0, 32'h0000_0010, 32'd0, 4'd0, rd, er, lat);
    chk("l0_rdata", 1, rd, 32'h0000_0004);
    chk("l0_lat",   1, 32'(lat), 32'd1);
    reset_in_wait(1);
    do_txn(1, 1'b1, 32'h0000_000C, 32'h1234_5678, 4'b1111, rd, er, lat);
    do_txn(1, 1'b0, 32'h0000_000C, 32'd0, 4'd0, rd, er, lat);
    chk("l0_full_store", 1, rd, 32'h1234_5678);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
